// File: rtl/pa_rvfpm_pkg.sv
// Shared types for the core-side XIF issue path towards the FPU coprocessor.
package pa_rvfpm;

    localparam int XLEN_DEF       = 32;
    localparam int X_ID_WIDTH_DEF = 4;

    typedef struct packed {
        logic [31:0]               instr;
        logic [X_ID_WIDTH_DEF-1:0] id;
        logic [XLEN_DEF-1:0]       rs0;
        logic [XLEN_DEF-1:0]       rs1;
        logic [1:0]                rs_valid;
    } entry_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic loadstore;
        logic exc;
    } resp_t;

    // ISSUED is transient: it folds back into WAIT or EMPTY on the handshake edge.
    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_WAIT   = 2'd1,
        S_ISSUED = 2'd2
    } head_state_e;

endpackage

// File: rtl/xif_fifo.sv
// Synchronous FIFO with flush; caller guarantees no push when full, no pop when empty.
module xif_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));

    always_ff @(posedge ck) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Flush discards everything not yet popped by re-aligning the read pointer.
    always_ff @(posedge ck) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/xif_issue_buffer.sv
// Issue buffer in front of the FPU XIF issue port: queues offloads, holds each request
// until issue_ready, and returns the captured response one cycle after the handshake.
module xif_issue_buffer
    import pa_rvfpm::*;
#(
    parameter int DEPTH      = 4,
    parameter int XLEN       = XLEN_DEF,
    parameter int X_ID_WIDTH = X_ID_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [X_ID_WIDTH-1:0]   in_id,
    input  logic [XLEN-1:0]         in_rs0,
    input  logic [XLEN-1:0]         in_rs1,
    input  logic [1:0]              in_rs_valid,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [31:0]             issue_instr,
    output logic [X_ID_WIDTH-1:0]   issue_id,
    output logic [XLEN-1:0]         issue_rs0,
    output logic [XLEN-1:0]         issue_rs1,
    output logic [1:0]              issue_rs_valid,
    input  logic                    issue_resp_accept,
    input  logic                    issue_resp_writeback,
    input  logic                    issue_resp_loadstore,
    input  logic                    issue_resp_exc,
    output logic                    resp_valid,
    output logic [X_ID_WIDTH-1:0]   resp_id,
    output logic [3:0]              resp_bits,
    output logic [CNT_WIDTH-1:0]    reject_cnt,
    output logic [$clog2(DEPTH):0]  count
);
    // Core side: push on in_valid && in_ready. FPU side: a request is offered while
    // issue_valid=1, held stable until issue_ready, and completes on issue_valid && issue_ready.
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + X_ID_WIDTH + 2 * XLEN + 2;

    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;
    logic          full;
    logic          push;
    logic          pop;
    logic [CW-1:0] next_count;
    head_state_e   head_state;
    resp_t         resp_q;

    assign in_ready   = !full && !flush && !rst;
    assign push       = in_valid && in_ready;
    assign pop        = issue_valid && issue_ready;
    assign wdata      = {in_instr, in_id, in_rs0, in_rs1, in_rs_valid};
    assign next_count = count + CW'(push) - CW'(pop);

    assign {issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid} = rdata;

    xif_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .ck    (ck),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full)
    );

    // Head FSM; issue_valid is its registered output and tracks count != 0.
    always_ff @(posedge ck) begin
        if (rst || flush) begin
            head_state <= S_EMPTY;
        end else if (next_count != '0) begin
            head_state <= S_WAIT;
        end else begin
            head_state <= S_EMPTY;
        end
    end

    assign issue_valid = (head_state == S_WAIT);

    always_ff @(posedge ck) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_q     <= '0;
            reject_cnt <= '0;
        end else begin
            resp_valid <= pop;
            if (pop) begin
                resp_id          <= issue_id;
                resp_q.accept    <= issue_resp_accept;
                resp_q.writeback <= issue_resp_writeback;
                resp_q.loadstore <= issue_resp_loadstore;
                resp_q.exc       <= issue_resp_exc;
                if (!issue_resp_accept && reject_cnt != '1) begin
                    reject_cnt <= reject_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign resp_bits = resp_q;

endmodule

// File: tb/tb_xif_issue_buffer.sv
// Bench for xif_issue_buffer: directed scenarios plus random traffic against a queue model.
module tb_xif_issue_buffer;
    import pa_rvfpm::*;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic        ck = 1'b0;
    logic        rst, flush, in_valid, issue_ready;
    logic [31:0] in_instr;
    logic [3:0]  in_id;
    logic [31:0] in_rs0, in_rs1;
    logic [1:0]  in_rs_valid;
    logic        acc, wb, ls, exc;

    logic        in_ready, issue_valid, resp_valid;
    logic [31:0] issue_instr, issue_rs0, issue_rs1;
    logic [3:0]  issue_id, resp_id, resp_bits;
    logic [1:0]  issue_rs_valid;
    logic [CNT_W-1:0] reject_cnt;
    logic [2:0]  count;

    entry_t exp_q[$];
    logic       m_rv;
    logic [3:0] m_rid, m_rbits;
    int         m_rcnt;
    int         total = 0;
    int         bad = 0;

    always #5 ck = ~ck;

    xif_issue_buffer #(
        .DEPTH(DEPTH), .XLEN(32), .X_ID_WIDTH(4), .CNT_WIDTH(CNT_W)
    ) dut (
        .ck(ck), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_id(in_id),
        .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rs_valid(in_rs_valid),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_id(issue_id), .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
        .issue_rs_valid(issue_rs_valid),
        .issue_resp_accept(acc), .issue_resp_writeback(wb),
        .issue_resp_loadstore(ls), .issue_resp_exc(exc),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_bits(resp_bits),
        .reject_cnt(reject_cnt), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [3:0] id);
        in_valid    = v;
        in_id       = id;
        in_instr    = $urandom;
        in_rs0      = $urandom;
        in_rs1      = $urandom;
        in_rs_valid = 2'($urandom_range(0, 3));
    endtask

    task automatic set_resp(input logic a);
        acc = a;
        wb  = 1'($urandom_range(0, 1));
        ls  = 1'($urandom_range(0, 1));
        exc = 1'($urandom_range(0, 1));
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check registers after the edge.
    task automatic tick();
        entry_t e;
        bit     rdy;
        bit     hs;
        @(negedge ck);
        rdy = !rst && !flush && exp_q.size() < DEPTH;
        check("in_ready", in_ready, rdy);
        check("issue_valid", issue_valid, exp_q.size() != 0);
        check("count", count, exp_q.size());
        if (exp_q.size() != 0) begin
            check("issue_instr", issue_instr, exp_q[0].instr);
            check("issue_id", issue_id, exp_q[0].id);
            check("issue_rs0", issue_rs0, exp_q[0].rs0);
            check("issue_rs1", issue_rs1, exp_q[0].rs1);
            check("issue_rs_valid", issue_rs_valid, exp_q[0].rs_valid);
        end
        if (rst) begin
            exp_q.delete();
            m_rv = 1'b0; m_rid = '0; m_rbits = '0; m_rcnt = 0;
        end else begin
            hs   = (exp_q.size() != 0) && issue_ready;
            m_rv = hs;
            if (hs) begin
                e       = exp_q.pop_front();
                m_rid   = e.id;
                m_rbits = {acc, wb, ls, exc};
                if (!acc && m_rcnt < CNT_MAX) m_rcnt++;
            end
            if (flush) exp_q.delete();
            else if (in_valid && rdy) begin
                e.instr = in_instr; e.id = in_id; e.rs0 = in_rs0; e.rs1 = in_rs1;
                e.rs_valid = in_rs_valid;
                exp_q.push_back(e);
            end
        end
        @(posedge ck);
        #1;
        check("resp_valid", resp_valid, m_rv);
        if (m_rv) begin
            check("resp_id", resp_id, m_rid);
            check("resp_bits", resp_bits, m_rbits);
        end
        check("reject_cnt", reject_cnt, m_rcnt);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
        set_in(1'b0, 4'd0);
        set_resp(1'b1);
        m_rv = 1'b0; m_rid = '0; m_rbits = '0; m_rcnt = 0;
        repeat (2) @(posedge ck);
        #1;
        check("rst_count", count, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_bits", resp_bits, 0);
        check("rst_reject_cnt", reject_cnt, 0);
        rst = 1'b0;

        // Single instruction, accepted.
        issue_ready = 1'b1;
        acc = 1'b1; wb = 1'b0; ls = 1'b0; exc = 1'b0;
        set_in(1'b1, 4'd3);
        in_instr = 32'h0020_F053;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("first_resp_bits", resp_bits, 4'b1000);

        // Fill with ids 1..4 while the FPU stalls, then drain back to back.
        issue_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 4'(i));
            tick();
        end
        set_in(1'b1, 4'd9);
        repeat (10) tick();
        in_valid = 1'b0;
        issue_ready = 1'b1;
        set_resp(1'b1);
        repeat (5) tick();

        // Full with a handshake and in_valid: no push that cycle, push the next.
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 4'(i + 6));
            tick();
        end
        issue_ready = 1'b1;
        set_in(1'b1, 4'd12);
        tick();
        issue_ready = 1'b0;
        tick();
        check("refill_count", count, 4);
        in_valid = 1'b0;
        issue_ready = 1'b1;
        repeat (5) tick();

        // Three rejects, then a long run of rejects to saturate.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'(i));
            set_resp(1'b0);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("reject_three", reject_cnt, 3);
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 4'(i));
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("reject_saturated", reject_cnt, CNT_MAX);

        // Flush coinciding with the handshake of head id 5.
        issue_ready = 1'b0;
        set_resp(1'b1);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'(i + 5));
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        issue_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_resp_id", resp_id, 5);
        tick();
        check("flush_empty", issue_valid, 0);

        // Reset while a request is held.
        issue_ready = 1'b0;
        set_in(1'b1, 4'd7);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        issue_ready = 1'b1;
        tick();
        rst = 1'b0;
        issue_ready = 1'b0;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)));
            issue_ready = 1'($urandom_range(0, 99) < 50);
            set_resp(1'($urandom_range(0, 99) < 70));
            flush = 1'($urandom_range(0, 99) < 3);
            rst   = 1'($urandom_range(0, 999) < 5);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xif_issue_buffer.md
Name: xif_issue_buffer

Overview:
- Core-side issue buffer that sits directly upstream of the FPU coprocessor's CORE-V-XIF issue port.
- Accepts offloaded instructions from the core pipeline, queues them in a small FIFO, and drives issue_valid/issue_req towards the FPU.
- Holds each request stable until issue_ready, captures the accept/reject response, and returns it to the core one cycle later with the instruction id.
- Exists to decouple core decode stalls from FPU readiness.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, integer operand width.
- X_ID_WIDTH, 4, instruction id width.
- CNT_WIDTH, 16, width of the saturating reject counter.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drops all queued, not-yet-issued entries.
- in_valid  in  1  core presents an instruction.
- in_ready  out  1  buffer can accept.
- in_instr  in  32  instruction word.
- in_id  in  X_ID_WIDTH  instruction id.
- in_rs0  in  XLEN  source operand 0.
- in_rs1  in  XLEN  source operand 1.
- in_rs_valid  in  2  operand valid bits.
- issue_valid  out  1  XIF issue request valid.
- issue_ready  in  1  FPU ready.
- issue_instr  out  32  head instruction.
- issue_id  out  X_ID_WIDTH  head id.
- issue_rs0  out  XLEN  head operand 0.
- issue_rs1  out  XLEN  head operand 1.
- issue_rs_valid  out  2  head operand valid bits.
- issue_resp_accept  in  1  FPU accepts the offload.
- issue_resp_writeback  in  1  result is written to the X register file.
- issue_resp_loadstore  in  1  instruction is a memory op.
- issue_resp_exc  in  1  instruction may raise an exception.
- resp_valid  out  1  one-cycle response pulse to core.
- resp_id  out  X_ID_WIDTH  id of the responded instruction.
- resp_bits  out  4  {accept, writeback, loadstore, exc}.
- reject_cnt  out  CNT_WIDTH  saturating count of rejected issues.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at posedge):
  - count=0; read and write pointers 0; issue_valid=0; resp_valid=0; resp_id=0; resp_bits=0; reject_cnt=0.
  - in_ready=0 while rst is high.
  - rst has priority over every other input, including a handshake in progress.
- Push:
  - in_ready = !full && !flush && !rst.
  - Push occurs when in_valid && in_ready. The entry stores instr, id, rs0, rs1 and rs_valid.
  - No bypass. An instruction pushed at edge N is first visible on issue_* after edge N.
- Issue:
  - issue_valid = (count != 0). issue_* are driven combinationally from the head entry.
  - Issue is a handshake: issue_valid && issue_ready at a posedge completes it and pops the head.
  - While issue_valid=1 and issue_ready=0, the head and all issue_* stay stable. Only rst or flush may withdraw them.
  - issue_resp_* are sampled only at the handshake edge.
- Response:
  - At the handshake edge, register resp_id=issue_id and resp_bits=issue_resp_*; assert resp_valid for exactly one cycle (latency 1).
  - Back-to-back handshakes give consecutive resp_valid pulses.
- Reject counter: if accept=0 at a handshake, reject_cnt increments, saturating at all-ones.
- Occupancy:
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - When full, in_ready=0 even if a pop happens that cycle. There is no full-pass-through.
- Pointers: width $clog2(DEPTH); wrap from DEPTH-1 to 0.
- Flush:
  - At the next edge, count=0 and rd_ptr=wr_ptr; any push that cycle is dropped (in_ready is already 0).
  - If a handshake completes in the flush cycle, its response is still delivered (resp_valid=1 next cycle) and reject_cnt is updated.
  - Flush with an empty FIFO has no effect.
- Control FSM (head state):
  - EMPTY (count==0) -> WAIT on push.
  - WAIT (issue_valid=1, no handshake yet) -> ISSUED on handshake.
  - ISSUED collapses back into WAIT or EMPTY in the same edge, depending on the remaining count.
  - Any state -> EMPTY on flush or rst.

Decomposition:
- Shared package pa_rvfpm holds:
  - the entry struct (instr, id, rs0, rs1, rs_valid);
  - the 4-bit response struct;
  - X_ID_WIDTH and XLEN defaults.
- Sub-module: xif_fifo, a parameterised synchronous FIFO with a flush input and count output. The top level adds the handshake, response register and counter.

Test Plan:
- Reset, then push id=3 instr=0x0020F053 with issue_ready=1, accept=1 -> issue_valid high one cycle after push; resp_valid pulses next cycle with resp_id=3, resp_bits=4'b1000.
- Push ids 1..4 with issue_ready=0 -> count=4, in_ready=0, issue_id=1 stable for 10 cycles; raise issue_ready -> resp ids 1,2,3,4 on consecutive cycles, count returns to 0.
- Full FIFO, in_valid=1, handshake completes -> no push that cycle; push accepted the next cycle; count goes 4→3→4.
- Three issues with accept=0 -> reject_cnt=3. Preload reject_cnt near saturation via a long run (CNT_WIDTH=4 build) -> holds at 15.
- Three queued entries, flush asserted in the same cycle as a handshake of head id=5 -> resp_valid with resp_id=5; count=0; issue_valid=0 the next cycle.
- rst asserted while issue_valid=1 and issue_ready=0 -> all outputs return to reset values at the next edge; no resp_valid pulse.
